approx_mul_err_monitor: RTL
===========================

Name: approx_mul_err_monitor

Overview:
Downstream characterisation stage for the 16x16 signed approximate radix-4 Booth multipliers. It consumes one (x, y, approximate product) sample per handshake. It recomputes the exact product with a radix-2 sequential shift-add multiplier, then forms the error distance. It accumulates run-time statistics: sample count, erroneous-sample count, sum of absolute error and maximum absolute error. It sits beside the combinational multiplier in silicon/FPGA error-evaluation harnesses.

Parameters:
WIDTH, 16, operand width in bits; the product is 2*WIDTH bits.
ACC_W, 48, width of the sum-of-absolute-error accumulator (ACC_W >= 2*WIDTH).
CNT_W, 32, width of the sample and error counters.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset, synchronous, active-low.
in_valid  input  1  sample valid.
in_ready  output  1  block can accept a sample.
x  input  WIDTH  multiplicand, two's complement.
y  input  WIDTH  multiplier, two's complement.
p_apx  input  2*WIDTH  approximate product under test, two's complement.
clear  input  1  synchronous statistics clear.
busy  output  1  computation in flight (state != IDLE).
res_valid  output  1  one-cycle pulse: ed_out/p_exact valid.
p_exact  output  2*WIDTH  exact signed product of the last sample.
ed_out  output  2*WIDTH+1  signed error distance p_apx - p_exact.
sample_cnt  output  CNT_W  samples processed.
err_cnt  output  CNT_W  samples with ed_out != 0.
sum_abs_err  output  ACC_W  sum of |ed|.
max_abs_err  output  2*WIDTH  max |ed|.

Behaviour:
- Reset: one clock, synchronous, active-low; fixed as decided. While rst_n=0 at a rising edge: state=IDLE, in_ready=1 after that edge, busy=0, res_valid=0. p_exact, ed_out, all counters and accumulators are 0. Reset mid-computation aborts the sample with no stats update and no res_valid.
- FSM states: IDLE -> MUL -> DIFF -> UPD -> IDLE.
- IDLE: in_ready=1. Handshake is in_valid & in_ready at an edge. On handshake, register x, y, p_apx. Register sign = x[MSB]^y[MSB] and the unsigned magnitudes |x|, |y| (WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow). Clear the partial product and the bit counter, then go to MUL.
- MUL: exactly WIDTH cycles. Each cycle, if the current multiplier magnitude LSB is 1, add the shifted multiplicand into the 2*WIDTH-bit partial product. Shift the multiplicand left and the multiplier right. When the counter reaches WIDTH-1, go to DIFF.
- DIFF (1 cycle): p_exact = sign ? -mag : mag. ed = sign-extend(p_apx) - sign-extend(p_exact), 2*WIDTH+1 bits. Register ed_out, p_exact and abs_err = |ed| (2*WIDTH bits, maximum 3*2^(2*WIDTH-2) fits). Go to UPD.
- UPD (1 cycle) updates the statistics:
  - sample_cnt += 1.
  - err_cnt += (ed != 0).
  - sum_abs_err += abs_err.
  - max_abs_err = max(max_abs_err, abs_err).
  - Set res_valid (registered), then go to IDLE.
- Latency: res_valid is high in the cycle following the edge WIDTH+2 edges after the accepting edge, i.e. 18 with WIDTH=16. In that same cycle in_ready=1 and the statistics already reflect the sample. Throughput is one sample per WIDTH+3 cycles at maximum.
- Saturation: counters and sum_abs_err saturate at all-ones and never wrap.
- in_valid while busy is ignored; there is no internal queue. x/y/p_apx may change freely after acceptance.
- clear:
  - At any edge, clear zeroes sample_cnt, err_cnt, sum_abs_err and max_abs_err.
  - If clear coincides with UPD, clear wins and the sample is not counted. res_valid, ed_out and p_exact for that sample are still produced.
  - clear does not affect the FSM or an in-flight computation.
- Simultaneous handshake and clear in IDLE: both take effect.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> no acceptance. After release, in_ready=1, busy=0, all stats 0, res_valid=0.
2. Exact sample: x=3, y=5, p_apx=15 -> res_valid pulse 18 edges after acceptance. p_exact=15, ed_out=0, sample_cnt=1, err_cnt=0, sum_abs_err=0. in_valid held high during busy does not re-accept until in_ready returns.
3. Corner operands: x=-32768, y=-32768, p_apx=0x3FFF0000 -> p_exact=0x40000000, ed_out=-65536, sum_abs_err=65536, max_abs_err=65536, err_cnt=1.
4. Accumulation: (x=100, y=-7, p_apx=-696) then (x=7, y=7, p_apx=45) -> ed_out +4 then -4. Final sample_cnt=2, err_cnt=2, sum_abs_err=8, max_abs_err=4.
5. clear: assert clear during UPD of a sample with ed=+4 -> res_valid pulses with ed_out=4, but all stats read 0 afterwards. A following exact sample gives sample_cnt=1.
6. Abort and saturation:
  - rst_n=0 at MUL cycle 5 -> no res_valid, stats 0, in_ready=1 after the reset edge.
  - Instance with ACC_W=32: two samples with x=0, y=0, p_apx=0x7FFFFFFF (|ed|=2^31-1) plus one with |ed|=2 -> sum_abs_err=0xFFFFFFFF (saturated).

Source files
------------

// File: rtl/approx_mul_err_monitor.sv
// approx_mul_err_monitor
// Characterisation stage for signed approximate multipliers. Each accepted
// (x, y, p_apx) sample is multiplied exactly by a radix-2 shift-add unit.
// The block then forms the error distance p_apx - p_exact and accumulates
// saturating statistics over all processed samples.
module approx_mul_err_monitor #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 48,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic [2*WIDTH-1:0]   p_apx,
    input  logic                 clear,
    output logic                 busy,
    output logic                 res_valid,
    output logic [2*WIDTH-1:0]   p_exact,
    output logic [2*WIDTH:0]     ed_out,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [ACC_W-1:0]     sum_abs_err,
    output logic [2*WIDTH-1:0]   max_abs_err
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    ONE_P   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]      ZERO_E  = {(PW+1){1'b0}};
    localparam logic [CW-1:0]    ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    LAST_C  = CW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}};
    localparam logic [ACC_W-1:0] MAX_ACC = {ACC_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIFF = 2'd2,
        S_UPD  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               accept_s;
    logic               in_ready_r;
    logic               busy_r;
    logic               res_valid_r;

    logic               sign_r;
    logic [PW-1:0]      mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [PW-1:0]      prod_r;
    logic [CW-1:0]      cnt_r;
    logic [PW-1:0]      p_apx_r;

    logic [PW-1:0]      p_exact_r;
    logic [PW:0]        ed_r;
    logic [PW-1:0]      abs_err_r;

    logic [CNT_W-1:0]   sample_cnt_r;
    logic [CNT_W-1:0]   err_cnt_r;
    logic [ACC_W-1:0]   sum_abs_err_r;
    logic [PW-1:0]      max_abs_err_r;

    logic [WIDTH-1:0]   abs_x_s;
    logic [WIDTH-1:0]   abs_y_s;
    logic [PW-1:0]      p_exact_s;
    logic [PW:0]        ed_s;
    logic [PW-1:0]      abs_err_s;
    logic [ACC_W:0]     sum_ext_s;

    assign accept_s = in_valid && (state_r == S_IDLE);

    // Next-state decode of the IDLE -> MUL -> DIFF -> UPD sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_nxt_s = S_MUL;
                else          state_nxt_s = S_IDLE;
            end
            S_MUL: begin
                if (cnt_r == LAST_C) state_nxt_s = S_DIFF;
                else                 state_nxt_s = S_MUL;
            end
            S_DIFF:  state_nxt_s = S_UPD;
            S_UPD:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register plus registered handshake/status flags derived from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == S_IDLE);
            busy_r      <= (state_nxt_s != S_IDLE);
            res_valid_r <= (state_r == S_UPD);
        end
    end

    // Operand magnitudes, signed exact product, error distance and its magnitude.
    always_comb begin
        abs_x_s   = x[WIDTH-1] ? (~x + ONE_W) : x;
        abs_y_s   = y[WIDTH-1] ? (~y + ONE_W) : y;
        p_exact_s = sign_r ? (~prod_r + ONE_P) : prod_r;
        ed_s      = {p_apx_r[PW-1], p_apx_r} - {p_exact_s[PW-1], p_exact_s};
        // |ed| never exceeds 3*2^(PW-2), so the low PW bits of the negation suffice.
        abs_err_s = ed_s[PW] ? (~ed_s[PW-1:0] + ONE_P) : ed_s[PW-1:0];
        sum_ext_s = (ACC_W+1)'(sum_abs_err_r) + (ACC_W+1)'(abs_err_r);
    end

    // Operand capture, shift-add multiply and error-distance registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_r    <= 1'b0;
            mcand_r   <= {PW{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            prod_r    <= {PW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            p_apx_r   <= {PW{1'b0}};
            p_exact_r <= {PW{1'b0}};
            ed_r      <= ZERO_E;
            abs_err_r <= {PW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        sign_r   <= x[WIDTH-1] ^ y[WIDTH-1];
                        mcand_r  <= {{WIDTH{1'b0}}, abs_x_s};
                        mplier_r <= abs_y_s;
                        prod_r   <= {PW{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        p_apx_r  <= p_apx;
                    end
                end
                S_MUL: begin
                    if (mplier_r[0]) prod_r <= prod_r + mcand_r;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + ONE_C;
                end
                S_DIFF: begin
                    p_exact_r <= p_exact_s;
                    ed_r      <= ed_s;
                    abs_err_r <= abs_err_s;
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating statistics; clear takes priority over the UPD-cycle update.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sample_cnt_r  <= {CNT_W{1'b0}};
            err_cnt_r     <= {CNT_W{1'b0}};
            sum_abs_err_r <= {ACC_W{1'b0}};
            max_abs_err_r <= {PW{1'b0}};
        end else if (state_r == S_UPD) begin
            if (sample_cnt_r != MAX_CNT) sample_cnt_r <= sample_cnt_r + ONE_CNT;
            if ((ed_r != ZERO_E) && (err_cnt_r != MAX_CNT)) err_cnt_r <= err_cnt_r + ONE_CNT;
            sum_abs_err_r <= sum_ext_s[ACC_W] ? MAX_ACC : sum_ext_s[ACC_W-1:0];
            if (abs_err_r > max_abs_err_r) max_abs_err_r <= abs_err_r;
        end
    end

    assign in_ready    = in_ready_r;
    assign busy        = busy_r;
    assign res_valid   = res_valid_r;
    assign p_exact     = p_exact_r;
    assign ed_out      = ed_r;
    assign sample_cnt  = sample_cnt_r;
    assign err_cnt     = err_cnt_r;
    assign sum_abs_err = sum_abs_err_r;
    assign max_abs_err = max_abs_err_r;

endmodule
